// File: rtl/sprite_attr_ram.sv
// sprite_attr_ram
//   Single-clock sprite attribute RAM. The host register bus writes through
//   the write port with per-byte lane enables. The sprite renderer fetches
//   attribute words through the read port. A hardware clear sequencer fills
//   every word with CLEAR_VAL after each reset and on software request, so
//   memory contents are always defined by hardware.
//
// Parameters
//   DATA_W    word width, a positive multiple of 8
//   ADDR_W    address width, depth = 2**ADDR_W
//   OUT_REG   0: 1-cycle read latency, 1: extra output register (2 cycles)
//   RDW_MODE  same-address read+write: 0 returns old word, 1 returns merged word
//   CLEAR_VAL value written to every word by the clear sequencer
//
// Ports
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   wr_en_i    write strobe
//   ben_i      byte-lane enables, bit k covers bits [8k+7:8k]
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read request
//   rd_addr_i  read address
//   rd_data_o  read data, held between reads
//   rd_valid_o one-cycle pulse when rd_data_o carries new data
//   clear_i    software clear request, level sampled while idle
//   busy_o     high while the clear sequencer owns the RAM
module sprite_attr_ram #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       OUT_REG   = 0,
  parameter int unsigned       RDW_MODE  = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [DATA_W/8-1:0]   ben_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  clear_i,
  output logic                  busy_o
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_data_w
    $error("sprite_attr_ram: DATA_W must be a positive multiple of 8");
  end

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  // Single physical write port, shared between the clear sequencer and the host.
  logic [NB-1:0]     mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              rd_fire;
  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Next-state, write-port arbitration and read acceptance
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mem_we     = '0;
    mem_waddr  = wr_addr_i;
    mem_wdata  = wr_data_i;
    rd_fire    = 1'b0;

    unique case (state_q)
      S_CLEAR: begin
        // Host write, read and clear requests are all dropped here.
        mem_we     = '1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = CLEAR_VAL;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (wr_en_i) begin
          mem_we = ben_i;
        end
        rd_fire = rd_en_i;
        // A write and a read in the same cycle as clear_i still complete.
        if (clear_i) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = S_CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Memory array: no writes at all while reset is asserted.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (mem_we[k]) begin
          mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
      end
    end
  end

  // Read word with optional write-first lane merge on an address collision.
  always_comb begin
    rd_old  = mem[rd_addr_i];
    rd_word = rd_old;
    if (RDW_MODE != 0 && rd_fire && (wr_addr_i == rd_addr_i)) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (mem_we[k]) begin
          rd_word[8*k +: 8] = wr_data_i[8*k +: 8];
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] pipe_data_q;
    logic              pipe_valid_q;

    // The second stage is not gated by the FSM, so reads already in flight
    // drain normally when a clear begins.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        pipe_data_q  <= '0;
        pipe_valid_q <= 1'b0;
        rd_data_q    <= '0;
        rd_valid_q   <= 1'b0;
      end else begin
        pipe_valid_q <= rd_fire;
        if (rd_fire) begin
          pipe_data_q <= rd_word;
        end
        rd_valid_q <= pipe_valid_q;
        if (pipe_valid_q) begin
          rd_data_q <= pipe_data_q;
        end
      end
    end
  end else begin : g_no_out_reg
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_fire;
        if (rd_fire) begin
          rd_data_q <= rd_word;
        end
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = (state_q == S_CLEAR);

endmodule

// File: tb/tb_sprite_attr_ram.sv
// tb_sprite_attr_ram
//   Bench for sprite_attr_ram. Three instances share every input:
//   dut0 (OUT_REG=0, RDW_MODE=0), dut1 (OUT_REG=0, RDW_MODE=1) and
//   dut2 (OUT_REG=1, RDW_MODE=0). Expected read words are pushed to one
//   queue per instance when a read is driven and are popped whenever that
//   instance pulses rd_valid_o.
module tb_sprite_attr_ram;

  localparam int unsigned N = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  ben;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic        rd_en;
  logic [7:0]  raddr;
  logic        clr;

  logic [31:0] rdata0, rdata1, rdata2;
  logic        rvalid0, rvalid1, rvalid2;
  logic        busy0, busy1, busy2;

  always #5 clk = ~clk;

  sprite_attr_ram #(.DATA_W(32), .ADDR_W(8), .OUT_REG(0), .RDW_MODE(0), .CLEAR_VAL(32'h0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .ben_i(ben), .wr_addr_i(waddr),
    .wr_data_i(wdata), .rd_en_i(rd_en), .rd_addr_i(raddr), .rd_data_o(rdata0),
    .rd_valid_o(rvalid0), .clear_i(clr), .busy_o(busy0));

  sprite_attr_ram #(.DATA_W(32), .ADDR_W(8), .OUT_REG(0), .RDW_MODE(1), .CLEAR_VAL(32'h0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .ben_i(ben), .wr_addr_i(waddr),
    .wr_data_i(wdata), .rd_en_i(rd_en), .rd_addr_i(raddr), .rd_data_o(rdata1),
    .rd_valid_o(rvalid1), .clear_i(clr), .busy_o(busy1));

  sprite_attr_ram #(.DATA_W(32), .ADDR_W(8), .OUT_REG(1), .RDW_MODE(0), .CLEAR_VAL(32'h0)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .ben_i(ben), .wr_addr_i(waddr),
    .wr_data_i(wdata), .rd_en_i(rd_en), .rd_addr_i(raddr), .rd_data_o(rdata2),
    .rd_valid_o(rvalid2), .clear_i(clr), .busy_o(busy2));

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] model [N];
  bit          blocked = 1'b1;
  logic [31:0] e0, e1, e2;
  int          pipe_run = 0;
  int          pipe_run_last = 0;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) model[i] = 32'h0;
  endfunction

  // Drives one cycle of stimulus from a negedge, updates the model and
  // queues expected read results, then returns at the next negedge.
  task automatic drive_cycle(input logic we, input logic [3:0] be, input logic [7:0] wa,
                             input logic [31:0] wd, input logic re, input logic [7:0] ra,
                             input logic cl);
    logic [31:0] old_w, new_w;
    wr_en = we; ben = be; waddr = wa; wdata = wd;
    rd_en = re; raddr = ra; clr = cl;
    if (!blocked) begin
      if (re) begin
        old_w = model[ra];
        new_w = (we && wa == ra) ? lane_merge(old_w, wd, be) : old_w;
        q0.push_back(old_w);
        q1.push_back(new_w);
        q2.push_back(old_w);
      end
      if (we) model[wa] = lane_merge(model[wa], wd, be);
    end
    @(negedge clk);
    wr_en = 1'b0; ben = 4'h0; waddr = 8'h0; wdata = 32'h0;
    rd_en = 1'b0; raddr = 8'h0; clr = 1'b0;
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL sb0_unexpected_valid: got data=%h, required no valid", rdata0);
      end else begin
        e0 = q0.pop_front();
        if (rdata0 !== e0) begin
          bad++;
          $display("FAIL sb0_data: got %h, required %h", rdata0, e0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid1 === 1'b1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL sb1_unexpected_valid: got data=%h, required no valid", rdata1);
      end else begin
        e1 = q1.pop_front();
        if (rdata1 !== e1) begin
          bad++;
          $display("FAIL sb1_data: got %h, required %h", rdata1, e1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid2 === 1'b1) begin
      pipe_run++;
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL sb2_unexpected_valid: got data=%h, required no valid", rdata2);
      end else begin
        e2 = q2.pop_front();
        if (rdata2 !== e2) begin
          bad++;
          $display("FAIL sb2_data: got %h, required %h", rdata2, e2);
        end
      end
    end else begin
      if (pipe_run != 0) pipe_run_last = pipe_run;
      pipe_run = 0;
    end
  end

  task automatic test_reset();
    int cnt;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1 || busy2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy: got %b%b%b, required 111", busy0, busy1, busy2);
    end
    total++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b%b%b, required 000", rvalid0, rvalid1, rvalid2);
    end
    total++;
    if (rdata0 !== 32'h0 || rdata2 !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata: got %h/%h, required 00000000", rdata0, rdata2);
    end
    rst_n = 1'b1;
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 600) begin cnt++; @(negedge clk); end
    total++;
    if (cnt != 256) begin
      bad++;
      $display("FAIL initial_clear_len: got %0d cycles, required 256", cnt);
    end
    blocked = 1'b0;
    model_clear();

    // Garbage, then a 2-cycle reset pulse must wipe it.
    drive_cycle(1, 4'hF, 8'd0,   32'hDEAD0000, 0, 0, 0);
    drive_cycle(1, 4'hF, 8'd127, 32'hDEAD007F, 0, 0, 0);
    drive_cycle(1, 4'hF, 8'd255, 32'hDEAD00FF, 0, 0, 0);
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 1, 8'd127, 0);
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 0, 0, 0);
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 0, 0, 0);
    rst_n = 1'b0;
    blocked = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 600) begin cnt++; @(negedge clk); end
    total++;
    if (cnt != 256) begin
      bad++;
      $display("FAIL reset_clear_len: got %0d cycles, required 256", cnt);
    end
    total++;
    if (busy2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy2_end: got %b, required 0", busy2);
    end
    blocked = 1'b0;
    model_clear();
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 1, 8'd0, 0);
    total++;
    if (rdata0 !== 32'h0) begin
      bad++;
      $display("FAIL reset_addr0: got %h, required 00000000", rdata0);
    end
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 1, 8'd127, 0);
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 1, 8'd255, 0);
    total++;
    if (rdata0 !== 32'h0) begin
      bad++;
      $display("FAIL reset_addr255: got %h, required 00000000", rdata0);
    end
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_byte_lanes();
    drive_cycle(1, 4'b1111, 8'd5, 32'hAABBCCDD, 0, 0, 0);
    drive_cycle(1, 4'b0101, 8'd5, 32'h11223344, 0, 0, 0);
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 1, 8'd5, 0);
    total++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hAA22CC44) begin
      bad++;
      $display("FAIL lanes_lat1: got valid=%b data=%h, required valid=1 data=aa22cc44", rvalid0, rdata0);
    end
    total++;
    if (rvalid2 !== 1'b0) begin
      bad++;
      $display("FAIL lanes_pipe_early: got valid=%b, required 0", rvalid2);
    end
    @(negedge clk);
    total++;
    if (rvalid0 !== 1'b0 || rdata0 !== 32'hAA22CC44) begin
      bad++;
      $display("FAIL lanes_pulse_hold: got valid=%b data=%h, required valid=0 data=aa22cc44", rvalid0, rdata0);
    end
    total++;
    if (rvalid2 !== 1'b1 || rdata2 !== 32'hAA22CC44) begin
      bad++;
      $display("FAIL lanes_lat2: got valid=%b data=%h, required valid=1 data=aa22cc44", rvalid2, rdata2);
    end
    @(negedge clk);
  endtask

  task automatic test_rdw();
    drive_cycle(1, 4'b0011, 8'd9, 32'hFFFFFFFF, 1, 8'd9, 0);
    total++;
    if (rdata0 !== 32'h00000000) begin
      bad++;
      $display("FAIL rdw_mode0: got %h, required 00000000", rdata0);
    end
    total++;
    if (rdata1 !== 32'h0000FFFF) begin
      bad++;
      $display("FAIL rdw_mode1: got %h, required 0000ffff", rdata1);
    end
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 1, 8'd9, 0);
    total++;
    if (rdata0 !== 32'h0000FFFF || rdata1 !== 32'h0000FFFF) begin
      bad++;
      $display("FAIL rdw_later: got %h/%h, required 0000ffff", rdata0, rdata1);
    end
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 0, 0, 0);
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_clear_blocked();
    int cnt;
    // Write and read in the clear-start cycle both complete.
    drive_cycle(1, 4'hF, 8'd7, 32'h00000077, 1, 8'd5, 1);
    blocked = 1'b1;
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 600) begin
      cnt++;
      if (cnt <= 10) drive_cycle(1, 4'hF, 8'd3, 32'hDEADBEEF, 1, 8'd3, 1);
      else           drive_cycle(0, 4'h0, 8'd0, 32'h0, 0, 0, 1);
    end
    total++;
    if (cnt != 256) begin
      bad++;
      $display("FAIL sw_clear_len: got %0d cycles, required 256", cnt);
    end
    blocked = 1'b0;
    model_clear();
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 1, 8'd3, 0);
    total++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'h0) begin
      bad++;
      $display("FAIL blocked_addr3: got valid=%b data=%h, required valid=1 data=00000000", rvalid0, rdata0);
    end
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 1, 8'd5, 0);
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 0, 0, 0);
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 4'hF, 8'(i), 32'h10 + 32'(i), 0, 0, 0);
    end
    pipe_run_last = 0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 4'h0, 8'd0, 32'h0, 1, 8'(i), 0);
    end
    repeat (3) @(negedge clk);
    total++;
    if (pipe_run_last != 4) begin
      bad++;
      $display("FAIL pipe_valid_run: got %0d cycles, required 4", pipe_run_last);
    end
    total++;
    if (rdata2 !== 32'h13) begin
      bad++;
      $display("FAIL pipe_last_data: got %h, required 00000013", rdata2);
    end
  endtask

  task automatic test_reset_midclear();
    int cnt;
    drive_cycle(1, 4'hF, 8'd200, 32'h5, 0, 0, 0);
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 1, 8'd200, 0);
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 0, 0, 1);
    blocked = 1'b1;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy0 !== 1'b1 || busy2 !== 1'b1) begin
      bad++;
      $display("FAIL midclear_reset_busy: got %b/%b, required 1", busy0, busy2);
    end
    rst_n = 1'b1;
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 600) begin cnt++; @(negedge clk); end
    total++;
    if (cnt != 256) begin
      bad++;
      $display("FAIL midclear_len: got %0d cycles, required 256", cnt);
    end
    blocked = 1'b0;
    model_clear();
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 1, 8'd200, 0);
    total++;
    if (rdata0 !== 32'h0) begin
      bad++;
      $display("FAIL midclear_addr200: got %h, required 00000000", rdata0);
    end
    drive_cycle(0, 4'h0, 8'd0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_drain();
    repeat (4) @(negedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d/%0d pending reads, required 0/0/0", q0.size(), q1.size(), q2.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; ben = 4'h0; waddr = 8'h0; wdata = 32'h0;
    rd_en = 1'b0; raddr = 8'h0; clr = 1'b0;
    test_reset();
    test_byte_lanes();
    test_rdw();
    test_clear_blocked();
    test_back_to_back();
    test_reset_midclear();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
